// File: rtl/slave_rx_txn_assembler.sv
// -----------------------------------------------------------------------------
// slave_rx_txn_assembler
//
// Gathers the per-field outputs of the chiplet slave RX FSM into one
// transaction record and offers it to the chiplet core over valid/ready.
//
// Ports
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   i_rx_*/i_rx_*_valid   cmd, addr, length, feature0/1 and data-word fields
//   o_rx_ready            fields are accepted this cycle (low while holding)
//   o_txn_valid           assembled record is available
//   i_txn_ready           consumer takes the record
//   o_txn_cmd/addr/length/feature0/feature1/data   assembled record
//   o_txn_err             record error flag, qualified by o_txn_valid
//   o_drop_cnt            saturating count of records aborted by a new cmd
// -----------------------------------------------------------------------------
module slave_rx_txn_assembler #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned MAX_WORDS = 32,
   parameter int unsigned DATA_W    = WORD_SIZE * MAX_WORDS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           i_rx_cmd,
   input  logic                 i_rx_cmd_valid,
   input  logic [WORD_SIZE-1:0] i_rx_addr,
   input  logic                 i_rx_addr_valid,
   input  logic [2:0]           i_rx_length,
   input  logic                 i_rx_length_valid,
   input  logic [5:0]           i_rx_feature0,
   input  logic                 i_rx_feature0_valid,
   input  logic [5:0]           i_rx_feature1,
   input  logic                 i_rx_feature1_valid,
   input  logic [WORD_SIZE-1:0] i_rx_data,
   input  logic                 i_rx_data_valid,
   output logic                 o_rx_ready,
   output logic                 o_txn_valid,
   input  logic                 i_txn_ready,
   output logic [2:0]           o_txn_cmd,
   output logic [WORD_SIZE-1:0] o_txn_addr,
   output logic [2:0]           o_txn_length,
   output logic [5:0]           o_txn_feature0,
   output logic [5:0]           o_txn_feature1,
   output logic [DATA_W-1:0]    o_txn_data,
   output logic                 o_txn_err,
   output logic [7:0]           o_drop_cnt
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned IDX_W = $clog2(MAX_WORDS);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t               state_q, state_d;
   logic [2:0]           cmd_q, cmd_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [2:0]           len_q, len_d;
   logic [5:0]           f0_q, f0_d;
   logic [5:0]           f1_q, f1_d;
   logic [WORD_SIZE-1:0] word_q [MAX_WORDS];
   logic [WORD_SIZE-1:0] word_d [MAX_WORDS];
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 len_seen_q, len_seen_d;
   logic                 addr_seen_q, addr_seen_d;
   logic                 err_q, err_d;
   logic [7:0]           drop_q, drop_d;

   logic                 cmd_err, len_err, fmt_err, addr_req, complete;
   logic [CNT_W-1:0]     w_exp, w_lim;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      len_d       = len_q;
      f0_d        = f0_q;
      f1_d        = f1_q;
      word_d      = word_q;
      cnt_d       = cnt_q;
      len_seen_d  = len_seen_q;
      addr_seen_d = addr_seen_q;
      err_d       = err_q;
      drop_d      = drop_q;
      cmd_err     = 1'b0;
      len_err     = 1'b0;
      fmt_err     = 1'b0;
      addr_req    = 1'b0;
      complete    = 1'b0;
      w_exp       = '0;
      w_lim       = '0;

      if (state_q == HOLD) begin
         if (i_txn_ready) state_d = IDLE;
      end else begin
         // A cmd always opens a fresh record; in COLLECT it aborts the old one.
         if (i_rx_cmd_valid) begin
            cmd_d       = i_rx_cmd;
            addr_d      = '0;
            len_d       = '0;
            f0_d        = '0;
            f1_d        = '0;
            for (int unsigned k = 0; k < MAX_WORDS; k++) word_d[k] = '0;
            cnt_d       = '0;
            len_seen_d  = 1'b0;
            addr_seen_d = 1'b0;
            err_d       = 1'b0;
            if (state_q == COLLECT && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         end

         if (i_rx_cmd_valid || state_q == COLLECT) begin
            if (i_rx_addr_valid) begin
               addr_d      = i_rx_addr;
               addr_seen_d = 1'b1;
            end
            if (i_rx_length_valid) begin
               len_d      = i_rx_length;
               len_seen_d = 1'b1;
            end
            if (i_rx_feature0_valid) f0_d = i_rx_feature0;
            if (i_rx_feature1_valid) f1_d = i_rx_feature1;

            cmd_err  = (cmd_d > 3'b010);
            len_err  = len_seen_d && (len_d > 3'b101);
            fmt_err  = cmd_err || len_err;
            addr_req = !fmt_err && (cmd_d != 3'b010);
            if (fmt_err || cmd_d == 3'b000) w_exp = '0;
            else                            w_exp = CNT_W'(1) << len_d;

            // Until length is known the word count is bounded only by the
            // slot count; once known, excess words are dropped and flagged.
            w_lim = len_seen_d ? w_exp : CNT_W'(MAX_WORDS);
            if (i_rx_data_valid) begin
               if (cnt_d < w_lim) begin
                  word_d[cnt_d[IDX_W-1:0]] = i_rx_data;
                  cnt_d                    = cnt_d + CNT_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end

            // Words taken before a short length arrived can leave the count
            // above W; treat that as overflow and blank the surplus slots.
            complete = len_seen_d && (addr_seen_d || !addr_req) && (cnt_d >= w_exp);
            if (fmt_err || (len_seen_d && cnt_d > w_exp)) err_d = 1'b1;

            if (complete) begin
               for (int unsigned k = 0; k < MAX_WORDS; k++)
                  if (CNT_W'(k) >= w_exp) word_d[k] = '0;
               state_d = HOLD;
            end else begin
               state_d = COLLECT;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         f0_q        <= '0;
         f1_q        <= '0;
         for (int unsigned k = 0; k < MAX_WORDS; k++) word_q[k] <= '0;
         cnt_q       <= '0;
         len_seen_q  <= 1'b0;
         addr_seen_q <= 1'b0;
         err_q       <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         f0_q        <= f0_d;
         f1_q        <= f1_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         len_seen_q  <= len_seen_d;
         addr_seen_q <= addr_seen_d;
         err_q       <= err_d;
         drop_q      <= drop_d;
      end
   end

   assign o_rx_ready     = (state_q != HOLD);
   assign o_txn_valid    = (state_q == HOLD);
   assign o_txn_cmd      = cmd_q;
   assign o_txn_addr     = addr_q;
   assign o_txn_length   = len_q;
   assign o_txn_feature0 = f0_q;
   assign o_txn_feature1 = f1_q;
   assign o_txn_err      = err_q;
   assign o_drop_cnt     = drop_q;

   for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
      assign o_txn_data[g*WORD_SIZE +: WORD_SIZE] = word_q[g];
   end

endmodule

// File: tb/tb_slave_rx_txn_assembler.sv
// -----------------------------------------------------------------------------
// tb_slave_rx_txn_assembler
//
// Directed bench for slave_rx_txn_assembler. Inputs change 1 ns after the
// rising edge and outputs are checked there, away from the active edge.
// -----------------------------------------------------------------------------
module tb_slave_rx_txn_assembler;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    i_rx_cmd;
   logic          i_rx_cmd_valid;
   logic [31:0]   i_rx_addr;
   logic          i_rx_addr_valid;
   logic [2:0]    i_rx_length;
   logic          i_rx_length_valid;
   logic [5:0]    i_rx_feature0;
   logic          i_rx_feature0_valid;
   logic [5:0]    i_rx_feature1;
   logic          i_rx_feature1_valid;
   logic [31:0]   i_rx_data;
   logic          i_rx_data_valid;
   logic          o_rx_ready;
   logic          o_txn_valid;
   logic          i_txn_ready;
   logic [2:0]    o_txn_cmd;
   logic [31:0]   o_txn_addr;
   logic [2:0]    o_txn_length;
   logic [5:0]    o_txn_feature0;
   logic [5:0]    o_txn_feature1;
   logic [1023:0] o_txn_data;
   logic          o_txn_err;
   logic [7:0]    o_drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   slave_rx_txn_assembler #(
      .WORD_SIZE (32),
      .MAX_WORDS (32)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_rx_cmd            (i_rx_cmd),
      .i_rx_cmd_valid      (i_rx_cmd_valid),
      .i_rx_addr           (i_rx_addr),
      .i_rx_addr_valid     (i_rx_addr_valid),
      .i_rx_length         (i_rx_length),
      .i_rx_length_valid   (i_rx_length_valid),
      .i_rx_feature0       (i_rx_feature0),
      .i_rx_feature0_valid (i_rx_feature0_valid),
      .i_rx_feature1       (i_rx_feature1),
      .i_rx_feature1_valid (i_rx_feature1_valid),
      .i_rx_data           (i_rx_data),
      .i_rx_data_valid     (i_rx_data_valid),
      .o_rx_ready          (o_rx_ready),
      .o_txn_valid         (o_txn_valid),
      .i_txn_ready         (i_txn_ready),
      .o_txn_cmd           (o_txn_cmd),
      .o_txn_addr          (o_txn_addr),
      .o_txn_length        (o_txn_length),
      .o_txn_feature0      (o_txn_feature0),
      .o_txn_feature1      (o_txn_feature1),
      .o_txn_data          (o_txn_data),
      .o_txn_err           (o_txn_err),
      .o_drop_cnt          (o_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      i_rx_cmd            = '0;
      i_rx_cmd_valid      = 1'b0;
      i_rx_addr           = '0;
      i_rx_addr_valid     = 1'b0;
      i_rx_length         = '0;
      i_rx_length_valid   = 1'b0;
      i_rx_feature0       = '0;
      i_rx_feature0_valid = 1'b0;
      i_rx_feature1       = '0;
      i_rx_feature1_valid = 1'b0;
      i_rx_data           = '0;
      i_rx_data_valid     = 1'b0;
   endtask

   // One clock: inputs set beforehand are sampled, then valids drop.
   task automatic step();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic hdr(input logic [2:0] cmd, input logic [2:0] len,
                      input logic addr_v, input logic [31:0] addr);
      i_rx_cmd          = cmd;
      i_rx_cmd_valid    = 1'b1;
      i_rx_length       = len;
      i_rx_length_valid = 1'b1;
      i_rx_addr         = addr;
      i_rx_addr_valid   = addr_v;
   endtask

   task automatic word(input logic [31:0] d);
      i_rx_data       = d;
      i_rx_data_valid = 1'b1;
      step();
   endtask

   task automatic ack(input string tag);
      i_txn_ready = 1'b1;
      step();
      i_txn_ready = 1'b0;
      check({tag, "_ack_valid"}, o_txn_valid, 1'b0);
      check({tag, "_ack_rdy"}, o_rx_ready, 1'b1);
   endtask

   initial begin
      clr();
      i_txn_ready = 1'b0;
      rst_n       = 1'b0;
      repeat (2) step();
      check("rst_valid", o_txn_valid, 1'b0);
      check("rst_rdy",   o_rx_ready, 1'b1);
      check("rst_drop",  o_drop_cnt, 8'd0);
      check("rst_err",   o_txn_err, 1'b0);
      check("rst_cmd",   o_txn_cmd, 3'd0);
      check("rst_addr",  o_txn_addr, 32'd0);
      check("rst_len",   o_txn_length, 3'd0);
      check("rst_feat",  {o_txn_feature1, o_txn_feature0}, 12'd0);
      check("rst_data",  |o_txn_data, 1'b0);
      rst_n = 1'b1;
      step();

      // Lightweight write, 2 words
      hdr(3'b001, 3'b001, 1'b1, 32'hFFDD0000);
      step();
      check("lw_hdr_valid", o_txn_valid, 1'b0);
      check("lw_hdr_rdy",   o_rx_ready, 1'b1);
      word(32'h000000AA);
      check("lw_w0_valid", o_txn_valid, 1'b0);
      word(32'h000000BB);
      check("lw_valid", o_txn_valid, 1'b1);
      check("lw_rdy",   o_rx_ready, 1'b0);
      check("lw_cmd",   o_txn_cmd, 3'b001);
      check("lw_addr",  o_txn_addr, 32'hFFDD0000);
      check("lw_len",   o_txn_length, 3'b001);
      check("lw_data",  o_txn_data[127:0], 128'h000000BB_000000AA);
      check("lw_hi",    |o_txn_data[1023:64], 1'b0);
      check("lw_err",   o_txn_err, 1'b0);
      check("lw_feat",  {o_txn_feature1, o_txn_feature0}, 12'd0);
      ack("lw");

      // Extended write with features, 4 words
      hdr(3'b001, 3'b010, 1'b1, 32'h00000888);
      i_rx_feature0 = 6'h01; i_rx_feature0_valid = 1'b1;
      i_rx_feature1 = 6'h3F; i_rx_feature1_valid = 1'b1;
      step();
      word(32'h00001234);
      word(32'h00005678);
      word(32'h00002444);
      check("ew_w2_valid", o_txn_valid, 1'b0);
      word(32'h00003666);
      check("ew_valid", o_txn_valid, 1'b1);
      check("ew_data",  o_txn_data[127:0], 128'h00003666_00002444_00005678_00001234);
      check("ew_hi",    |o_txn_data[1023:128], 1'b0);
      check("ew_f0",    o_txn_feature0, 6'h01);
      check("ew_f1",    o_txn_feature1, 6'h3F);
      check("ew_addr",  o_txn_addr, 32'h00000888);
      check("ew_err",   o_txn_err, 1'b0);
      ack("ew");

      // Read request in a single cycle, consumer stalls 5 cycles
      hdr(3'b000, 3'b010, 1'b1, 32'h00000AAA);
      step();
      check("rr_valid", o_txn_valid, 1'b1);
      check("rr_data",  |o_txn_data, 1'b0);
      check("rr_cmd",   o_txn_cmd, 3'b000);
      check("rr_len",   o_txn_length, 3'b010);
      for (int i = 0; i < 5; i++) begin
         hdr(3'b001, 3'b000, 1'b1, 32'h00005555);
         word(32'hDEADBEEF);
         check("rr_hold_valid", o_txn_valid, 1'b1);
         check("rr_hold_rdy",   o_rx_ready, 1'b0);
         check("rr_hold_addr",  o_txn_addr, 32'h00000AAA);
         check("rr_hold_cmd",   o_txn_cmd, 3'b000);
         check("rr_hold_data",  |o_txn_data, 1'b0);
      end
      ack("rr");

      // Abort: second cmd replaces a partial write
      hdr(3'b001, 3'b010, 1'b1, 32'h00000100);
      step();
      word(32'h00000011);
      word(32'h00000022);
      check("ab_mid_valid", o_txn_valid, 1'b0);
      hdr(3'b010, 3'b000, 1'b0, 32'h0);
      step();
      check("ab_new_valid", o_txn_valid, 1'b0);
      check("ab_drop",      o_drop_cnt, 8'd1);
      word(32'h00000033);
      check("ab_valid", o_txn_valid, 1'b1);
      check("ab_cmd",   o_txn_cmd, 3'b010);
      check("ab_addr",  o_txn_addr, 32'h0);
      check("ab_data",  o_txn_data[127:0], 128'h33);
      check("ab_err",   o_txn_err, 1'b0);
      ack("ab");
      check("ab_drop_after", o_drop_cnt, 8'd1);

      // Length error: completes on length alone
      hdr(3'b001, 3'b111, 1'b0, 32'h0);
      step();
      check("le_valid", o_txn_valid, 1'b1);
      check("le_err",   o_txn_err, 1'b1);
      check("le_data",  |o_txn_data, 1'b0);
      check("le_len",   o_txn_length, 3'b111);
      ack("le");

      // Word overflow: 3 words for a 1-word write, address arrives last
      hdr(3'b001, 3'b000, 1'b0, 32'h0);
      step();
      word(32'h0000000A);
      word(32'h0000000B);
      word(32'h0000000C);
      check("ov_wait_valid", o_txn_valid, 1'b0);
      i_rx_addr = 32'h00001234; i_rx_addr_valid = 1'b1;
      step();
      check("ov_valid", o_txn_valid, 1'b1);
      check("ov_err",   o_txn_err, 1'b1);
      check("ov_data",  o_txn_data[127:0], 128'h0A);
      check("ov_hi",    |o_txn_data[1023:32], 1'b0);
      check("ov_addr",  o_txn_addr, 32'h00001234);
      ack("ov");

      // Illegal command
      hdr(3'b110, 3'b000, 1'b0, 32'h0);
      step();
      check("ce_valid", o_txn_valid, 1'b1);
      check("ce_err",   o_txn_err, 1'b1);
      check("ce_cmd",   o_txn_cmd, 3'b110);
      ack("ce");

      // Reset while collecting
      hdr(3'b001, 3'b001, 1'b1, 32'h00000777);
      step();
      word(32'h00000001);
      check("rc_pre_valid", o_txn_valid, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rc_valid", o_txn_valid, 1'b0);
      check("rc_rdy",   o_rx_ready, 1'b1);
      check("rc_cmd",   o_txn_cmd, 3'd0);
      check("rc_addr",  o_txn_addr, 32'd0);
      check("rc_len",   o_txn_length, 3'd0);
      check("rc_data",  |o_txn_data, 1'b0);
      check("rc_drop",  o_drop_cnt, 8'd0);
      #1;
      rst_n = 1'b1;
      step();
      word(32'h00000002);
      word(32'h00000003);
      step();
      check("rc_post_valid", o_txn_valid, 1'b0);
      check("rc_post_data",  |o_txn_data, 1'b0);

      // Reset while holding
      hdr(3'b000, 3'b000, 1'b1, 32'h00000044);
      step();
      check("rh_pre_valid", o_txn_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rh_valid", o_txn_valid, 1'b0);
      check("rh_rdy",   o_rx_ready, 1'b1);
      check("rh_addr",  o_txn_addr, 32'd0);
      check("rh_err",   o_txn_err, 1'b0);
      #1;
      rst_n = 1'b1;
      repeat (3) step();
      check("rh_post_valid", o_txn_valid, 1'b0);
      check("rh_post_addr",  o_txn_addr, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
